sync_fifo_param: RTL and testbench

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_ram.sv | 25 ++
 rtl/sync_fifo_param.sv | 110 +++++++++++
 tb/tb_sync_fifo_param.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and width helpers for the parameterised synchronous FIFO.
package fifo_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_DEPTH    = 16;
  localparam int DEF_AF_GAP   = 2;
  localparam int DEF_AE_LEVEL = 2;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // One extra bit so the count can represent a completely full FIFO.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AW     = ptr_w(DEF_DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Synchronous FIFO with registered status flags and one-cycle error pulses.
// Define FIFO_FWFT_EN for first-word-fall-through output; default is 1-cycle registered read.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - DEF_AF_GAP,
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       din,
  input  logic                    write,
  input  logic                    read,
  output logic [DATA_W-1:0]       dout,
  output logic                    empty,
  output logic                    full,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [PW-1:0]     wr_ptr, rd_ptr, ram_raddr;
  logic [CW-1:0]     count_next;
  logic [DATA_W-1:0] ram_rdata, dout_next;
  logic              rd_ok, wr_ok;

  // A full FIFO can still take a write when a read frees a slot on the same edge.
  assign rd_ok = read && !empty;
  assign wr_ok = write && (!full || rd_ok);

`ifdef FIFO_FWFT_EN
  assign ram_raddr = rd_ptr + PW'(1);
`else
  assign ram_raddr = rd_ptr;
`endif

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (PW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok && rst),
    .waddr (wr_ptr),
    .wdata (din),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_comb begin
    count_next = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // In FWFT mode dout tracks the head: the entry behind it on a read, or din when it becomes the head.
  always_comb begin
    dout_next = dout;
`ifdef FIFO_FWFT_EN
    if (rd_ok) begin
      if (count == CW'(1)) begin
        if (wr_ok) dout_next = din;
      end else begin
        dout_next = ram_rdata;
      end
    end else if (wr_ok && empty) begin
      dout_next = din;
    end
`else
    if (rd_ok) dout_next = ram_rdata;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= (AE_LEVEL >= 0);
      almost_full  <= (AF_LEVEL <= 0);
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      dout         <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PW'(1);
      count        <= count_next;
      empty        <= (count_next == '0);
      full         <= (count_next == CW'(DEPTH));
      almost_empty <= (int'(count_next) <= AE_LEVEL);
      almost_full  <= (int'(count_next) >= AF_LEVEL);
      overflow     <= write && !wr_ok;
      underflow    <= read && empty;
      dout         <= dout_next;
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench: a default 16-deep FIFO (A) and a 4-deep FIFO (B, AF=3, AE=1).
// Expected dout values follow FIFO_FWFT_EN when the bench is built with it.
module tb_sync_fifo_param;

`ifdef FIFO_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] a_din = '0, b_din = '0;
  logic       a_write = 1'b0, a_read = 1'b0, b_write = 1'b0, b_read = 1'b0;
  logic [7:0] a_dout, b_dout;
  logic       a_empty, a_full, a_af, a_ae, a_ov, a_un;
  logic       b_empty, b_full, b_af, b_ae, b_ov, b_un;
  logic [4:0] a_count;
  logic [2:0] b_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] seq_a [6] = '{8'h94, 8'h0F, 8'h51, 8'h24, 8'h67, 8'hF3};
  logic [7:0] seq_b [5] = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
  logic [7:0] drain_reg [4] = '{8'hC4, 8'h3C, 8'h3C, 8'h3C};
  logic [7:0] wrap_b [3] = '{8'hD1, 8'hD2, 8'hD3};

  always #5 clk = ~clk;

  sync_fifo_param dut_a (
    .clk          (clk),
    .rst          (rst),
    .din          (a_din),
    .write        (a_write),
    .read         (a_read),
    .dout         (a_dout),
    .empty        (a_empty),
    .full         (a_full),
    .almost_full  (a_af),
    .almost_empty (a_ae),
    .count        (a_count),
    .overflow     (a_ov),
    .underflow    (a_un)
  );

  sync_fifo_param #(
    .DATA_W   (8),
    .DEPTH    (4),
    .AF_LEVEL (3),
    .AE_LEVEL (1)
  ) dut_b (
    .clk          (clk),
    .rst          (rst),
    .din          (b_din),
    .write        (b_write),
    .read         (b_read),
    .dout         (b_dout),
    .empty        (b_empty),
    .full         (b_full),
    .almost_full  (b_af),
    .almost_empty (b_ae),
    .count        (b_count),
    .overflow     (b_ov),
    .underflow    (b_un)
  );

  function automatic logic [7:0] pick(input logic [7:0] reg_v, input logic [7:0] fwft_v);
    return FWFT ? fwft_v : reg_v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag, input int cnt);
    check({tag, "_count"}, 32'(a_count), 32'(cnt));
    check({tag, "_empty"}, 32'(a_empty), 32'(cnt == 0));
    check({tag, "_full"},  32'(a_full),  32'(cnt == 16));
    check({tag, "_ae"},    32'(a_ae),    32'(cnt <= 2));
    check({tag, "_af"},    32'(a_af),    32'(cnt >= 14));
  endtask

  task automatic check_b(input string tag, input int cnt);
    check({tag, "_count"}, 32'(b_count), 32'(cnt));
    check({tag, "_empty"}, 32'(b_empty), 32'(cnt == 0));
    check({tag, "_full"},  32'(b_full),  32'(cnt == 4));
    check({tag, "_ae"},    32'(b_ae),    32'(cnt <= 1));
    check({tag, "_af"},    32'(b_af),    32'(cnt >= 3));
  endtask

  task automatic cycle_a(input logic w, input logic r, input logic [7:0] d);
    a_write = w; a_read = r; a_din = d;
    @(posedge clk); @(negedge clk);
    a_write = 1'b0; a_read = 1'b0;
  endtask

  task automatic cycle_b(input logic w, input logic r, input logic [7:0] d);
    b_write = w; b_read = r; b_din = d;
    @(posedge clk); @(negedge clk);
    b_write = 1'b0; b_read = 1'b0;
  endtask

  task automatic reset_cycle(input logic w, input logic r, input logic [7:0] d);
    rst = 1'b0; a_write = w; a_read = r; a_din = d;
    @(posedge clk); @(negedge clk);
    rst = 1'b1; a_write = 1'b0; a_read = 1'b0;
  endtask

  task automatic check_reset_a(input string tag);
    check_a(tag, 0);
    check({tag, "_ov"},   32'(a_ov),   32'd0);
    check({tag, "_un"},   32'(a_un),   32'd0);
    check({tag, "_dout"}, 32'(a_dout), 32'd0);
  endtask

  initial begin
    $display("[TB] start, FWFT=%0d", FWFT);

    // Reset state of both instances
    reset_cycle(1'b0, 1'b0, 8'h00);
    check_reset_a("rst0");
    check_b("rst0_b", 0);
    check("rst0_b_dout", 32'(b_dout), 32'd0);

    // Six writes then six reads, FIFO order and read latency
    for (int i = 0; i < 6; i++) begin
      cycle_a(1'b1, 1'b0, seq_a[i]);
      check_a($sformatf("wr%0d", i), i + 1);
      check($sformatf("wr%0d_dout", i), 32'(a_dout), 32'(pick(8'h00, 8'h94)));
    end
    for (int i = 0; i < 6; i++) begin
      cycle_a(1'b0, 1'b1, 8'h00);
      check_a($sformatf("rd%0d", i), 5 - i);
      check($sformatf("rd%0d_dout", i), 32'(a_dout),
            32'(pick(seq_a[i], (i < 5) ? seq_a[i + 1] : seq_a[5])));
    end
    check("rd_un", 32'(a_un), 32'd0);

    // Underflow: read while empty, alone and with a write
    cycle_a(1'b0, 1'b1, 8'h00);
    check("un1", 32'(a_un), 32'd1);
    check_a("un1", 0);
    check("un1_dout_hold", 32'(a_dout), 32'hF3);
    cycle_a(1'b0, 1'b0, 8'h00);
    check("un1_clear", 32'(a_un), 32'd0);
    cycle_a(1'b1, 1'b1, 8'hA5);
    check("un2", 32'(a_un), 32'd1);
    check_a("un2", 1);
    check("un2_dout", 32'(a_dout), 32'(pick(8'hF3, 8'hA5)));
    cycle_a(1'b0, 1'b0, 8'h00);
    check("un2_clear", 32'(a_un), 32'd0);
    cycle_a(1'b0, 1'b1, 8'h00);
    check("un2_read", 32'(a_dout), 32'hA5);
    check_a("un2_read", 0);

    // DEPTH=4: fill, overflow on the fifth write
    for (int i = 0; i < 4; i++) begin
      cycle_b(1'b1, 1'b0, seq_b[i]);
      check_b($sformatf("bwr%0d", i), i + 1);
      check($sformatf("bwr%0d_dout", i), 32'(b_dout), 32'(pick(8'h00, 8'hC1)));
    end
    cycle_b(1'b1, 1'b0, seq_b[4]);
    check("bov", 32'(b_ov), 32'd1);
    check_b("bov", 4);
    cycle_b(1'b0, 1'b0, 8'h00);
    check("bov_clear", 32'(b_ov), 32'd0);

    // Full with simultaneous read and write across the pointer wrap
    for (int i = 0; i < 3; i++) begin
      cycle_b(1'b1, 1'b1, 8'h3C);
      check($sformatf("brw%0d_ov", i), 32'(b_ov), 32'd0);
      check_b($sformatf("brw%0d", i), 4);
      check($sformatf("brw%0d_dout", i), 32'(b_dout), 32'(pick(seq_b[i], seq_b[i + 1])));
    end
    for (int i = 0; i < 4; i++) begin
      cycle_b(1'b0, 1'b1, 8'h00);
      check_b($sformatf("bdr%0d", i), 3 - i);
      check($sformatf("bdr%0d_dout", i), 32'(b_dout), 32'(pick(drain_reg[i], 8'h3C)));
    end
    for (int i = 0; i < 3; i++) begin
      cycle_b(1'b1, 1'b0, wrap_b[i]);
      check_b($sformatf("bwrap_wr%0d", i), i + 1);
    end
    check("bwrap_dout", 32'(b_dout), 32'(pick(8'h3C, 8'hD1)));
    for (int i = 0; i < 3; i++) begin
      cycle_b(1'b0, 1'b1, 8'h00);
      check_b($sformatf("bwrap_rd%0d", i), 2 - i);
      check($sformatf("bwrap_rd%0d_dout", i), 32'(b_dout),
            32'(pick(wrap_b[i], (i < 2) ? wrap_b[i + 1] : wrap_b[2])));
    end

    // Reset during traffic with read and write requested on the reset edge
    cycle_a(1'b1, 1'b0, 8'h11);
    cycle_a(1'b1, 1'b0, 8'h22);
    cycle_a(1'b1, 1'b0, 8'h33);
    check_a("pre_rst", 3);
    reset_cycle(1'b1, 1'b1, 8'h55);
    check_reset_a("mid_rst");
    check_b("mid_rst_b", 0);
    cycle_a(1'b0, 1'b0, 8'h00);
    check_reset_a("post_rst");
    cycle_a(1'b1, 1'b0, 8'h77);
    check_a("post_rst_wr", 1);
    check("post_rst_wr_dout", 32'(a_dout), 32'(pick(8'h00, 8'h77)));
    cycle_a(1'b0, 1'b1, 8'h00);
    check_a("post_rst_rd", 0);
    check("post_rst_rd_dout", 32'(a_dout), 32'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
